// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W     = 32;
    localparam int unsigned FETCH_INSTR_W    = 32;
    localparam int unsigned FETCH_FIFO_DEPTH = 4;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer: flush beats push, simultaneous push+pop keeps the count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_FIFO_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry storage; contents are qualified by the count, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited in-order memory requests and
// buffers responses for decode; redirects flush the buffer and drop in-flight returns.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = FETCH_ADDR_W,
    parameter int unsigned       INSTR_W    = FETCH_INSTR_W,
    parameter int unsigned       FIFO_DEPTH = FETCH_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC   = FETCH_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc,
    output logic [ADDR_W-1:0]  inst_pcplus4
);

    localparam int unsigned   CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_cnt;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [CW-1:0]     w_out_next;
    logic [CW-1:0]     w_fifo_count;
    logic [CW:0]       w_inflight;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_rsp_keep;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    assign w_redirect_pc = redirect_pc & ~(ADDR_W'(3));
    assign w_inflight    = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    // Every accepted request is guaranteed a buffer slot, so responses never need back-pressure.
    assign w_req_valid   = reset && !redirect_valid && !w_fifo_full && (w_inflight < DEPTH_C);
    assign w_req_fire    = w_req_valid && imem_req_ready;
    assign w_rsp_keep    = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop         = !w_fifo_empty && inst_ready;
    assign w_push_entry  = '{instr: imem_rsp_data, pc: r_rsp_pc};

    // Outstanding-request count after this cycle's handshakes and returns.
    always_comb begin
        w_out_next = r_outstanding;
        if (w_req_fire && !imem_rsp_valid) begin
            w_out_next = r_outstanding + CW'(1);
        end else if (!w_req_fire && imem_rsp_valid) begin
            w_out_next = r_outstanding - CW'(1);
        end else begin
            w_out_next = r_outstanding;
        end
    end

    // Request PC and the PC tag for the next kept response; kept responses are sequential from the last redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
            if (w_rsp_keep) begin
                r_rsp_pc <= r_rsp_pc + ADDR_W'(4);
            end
        end
    end

    // Credit counter and stale-response drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                r_drop_cnt <= w_out_next;
            end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_flush (redirect_valid),
        .i_push  (w_rsp_keep),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid     = !w_fifo_empty;
    assign inst_data      = w_fifo_empty ? '0 : w_head.instr;
    assign inst_pc        = w_fifo_empty ? '0 : w_head.pc;
    assign inst_pcplus4   = w_fifo_empty ? '0 : (w_head.pc + ADDR_W'(4));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a transaction-level memory and stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pcplus4;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_pcplus4   (inst_pcplus4)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        mq[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          mem_ready = 1'b0;
    bit          tb_redirect = 1'b0;
    logic [31:0] tb_rpc = 32'h0;
    bit          tb_inst_ready = 1'b0;
    logic [31:0] exp_req_addr = 32'h0;
    logic [31:0] exp_inst_pc = 32'h0;
    int          fifo_model = 0;
    int          n_fire = 0;
    int          n_pop = 0;
    logic [31:0] first_pop_pc = 32'h0;
    bit          first_pop_seen = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    bit          last_rsp = 1'b0;
    bit          last_pop = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        last_due       = -1;
        fifo_model     = 0;
        exp_req_addr   = 32'h0;
        exp_inst_pc    = 32'h0;
        prev_stall     = 1'b0;
        first_pop_seen = 1'b0;
    endtask

    task automatic cycle();
        bit          rsp_now;
        bit          keep;
        bit          fire;
        bit          pop;
        int          inflight;
        int          due;
        logic [31:0] req_addr;
        req_t        r;
        rsp_now = 1'b0;
        keep    = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r              = mq.pop_front();
            rsp_now        = 1'b1;
            keep           = !r.stale && !tb_redirect;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(r.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = mem_ready;
        redirect_valid = tb_redirect;
        redirect_pc    = tb_rpc;
        inst_ready     = tb_inst_ready;
        @(negedge clk);
        inflight = mq.size() + (rsp_now ? 1 : 0) + fifo_model;
        chk("req_valid", 32'(imem_req_valid), 32'(!tb_redirect && inflight < 4));
        chk("inst_valid", 32'(inst_valid), 32'(fifo_model != 0));
        if (prev_stall && !tb_redirect) begin
            chk("stall_hold_valid", 32'(imem_req_valid), 32'd1);
            chk("stall_hold_addr", imem_req_addr, prev_addr);
        end
        fire     = imem_req_valid && mem_ready;
        pop      = inst_valid && tb_inst_ready;
        req_addr = imem_req_addr;
        if (fire) begin
            chk("req_addr", imem_req_addr, exp_req_addr);
            exp_req_addr = exp_req_addr + 32'd4;
        end
        if (pop) begin
            chk("inst_pc", inst_pc, exp_inst_pc);
            chk("inst_data", inst_data, mem_word(exp_inst_pc));
            chk("inst_pcplus4", inst_pcplus4, exp_inst_pc + 32'd4);
            if (!first_pop_seen) begin
                first_pop_pc   = inst_pc;
                first_pop_seen = 1'b1;
            end
            exp_inst_pc = exp_inst_pc + 32'd4;
            n_pop++;
        end
        prev_stall = imem_req_valid && !mem_ready;
        prev_addr  = imem_req_addr;
        last_rsp   = rsp_now;
        last_pop   = pop;
        @(posedge clk);
        if (fire) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: req_addr, due: due, stale: 1'b0});
            n_fire++;
        end
        cyc++;
        if (tb_redirect) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            fifo_model     = 0;
            exp_inst_pc    = tb_rpc & ~32'h3;
            exp_req_addr   = tb_rpc & ~32'h3;
            first_pop_seen = 1'b0;
        end else begin
            fifo_model = fifo_model + (keep ? 1 : 0) - (pop ? 1 : 0);
        end
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_pcplus4", inst_pcplus4, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        // Reset held with a spurious response on the memory port.
        for (int i = 0; i < 10; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            @(negedge clk);
            chk("t1_req_valid", 32'(imem_req_valid), 32'd0);
            chk("t1_inst_valid", 32'(inst_valid), 32'd0);
            chk("t1_req_addr", imem_req_addr, 32'h0);
            chk("t1_inst_data", inst_data, 32'h0);
            @(posedge clk);
            #1;
        end
        imem_rsp_valid = 1'b0;
        reset = 1'b1;
        model_reset();

        // Single-cycle memory, decode always ready: one instruction per cycle.
        lat_min = 1; lat_max = 1; mem_ready = 1'b1; tb_inst_ready = 1'b1;
        n_pop = 0;
        repeat (30) cycle();
        chk("t2_pops", 32'(n_pop), 32'd28);

        // Decode stalled: exactly FIFO_DEPTH requests, then resume in order.
        do_reset();
        tb_inst_ready = 1'b0;
        n_fire = 0;
        repeat (12) cycle();
        chk("t3_fires", 32'(n_fire), 32'd4);
        chk("t3_req_valid_low", 32'(imem_req_valid), 32'd0);
        tb_inst_ready = 1'b1;
        n_pop = 0;
        repeat (20) cycle();
        chk("t3_first_pc", first_pop_pc, 32'h0);
        chk("t3_streaming", 32'(n_pop > 8), 32'd1);

        // Three-cycle memory, redirect with two requests in flight.
        do_reset();
        lat_min = 3; lat_max = 3;
        repeat (2) cycle();
        tb_redirect = 1'b1; tb_rpc = 32'h0000_0103;
        cycle();
        tb_redirect = 1'b0;
        chk("t4_next_addr", imem_req_addr, 32'h0000_0100);
        repeat (15) cycle();
        chk("t4_first_pc", first_pop_pc, 32'h0000_0100);

        // Redirect coinciding with a response and a decode handshake.
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (6) cycle();
        tb_redirect = 1'b1; tb_rpc = 32'h0000_2000;
        cycle();
        tb_redirect = 1'b0;
        chk("t5_rsp_at_redirect", 32'(last_rsp), 32'd1);
        chk("t5_pop_at_redirect", 32'(last_pop), 32'd1);
        repeat (10) cycle();
        chk("t5_first_pc", first_pop_pc, 32'h0000_2000);

        // Redirect to the top word, wrap, then asynchronous reset mid-stream.
        tb_redirect = 1'b1; tb_rpc = 32'hFFFF_FFFC;
        cycle();
        tb_redirect = 1'b0;
        repeat (6) cycle();
        chk("t6_first_pc", first_pop_pc, 32'hFFFF_FFFC);
        #2;
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("t6_async_inst_valid", 32'(inst_valid), 32'd0);
        chk("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_async_inst_pc", inst_pc, 32'h0);
        chk("t6_async_req_addr", imem_req_addr, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        repeat (6) cycle();
        chk("t6_restart_pc", first_pop_pc, 32'h0);

        // Randomized traffic: variable latency, back-pressure and redirects.
        do_reset();
        lat_min = 1; lat_max = 4;
        n_pop = 0;
        repeat (800) begin
            mem_ready     = ($urandom_range(0, 3) != 0);
            tb_inst_ready = ($urandom_range(0, 3) != 0);
            tb_redirect   = ($urandom_range(0, 24) == 0);
            tb_rpc        = $urandom;
            cycle();
        end
        tb_redirect = 1'b0;
        chk("rand_progress", 32'(n_pop > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
